// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART frame decoder
//
// Purpose: defaults for the frame decoder parameters, UART bit timing and the
// decoder state encoding. No ports.
package uart_pkg;

    localparam int          BYTE_W           = 8;
    localparam logic [7:0]  SOF_BYTE_DEF     = 8'hA5;
    localparam int          MAX_LEN_DEF      = 16;
    localparam int          CLKS_PER_BIT     = 434;
    // Ten byte times of ten bits each at CLKS_PER_BIT.
    localparam int          TIMEOUT_CLKS_DEF = 100 * CLKS_PER_BIT;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload storage for one frame
//
// Purpose: DEPTH x 8 register file, one synchronous write port and one
// combinational read port. Contents are not reset.
// Ports:
//   clk      - clock, write on posedge
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - byte to store
//   rd_addr  - read index
//   rd_data  - byte at rd_addr, combinational
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = MAX_LEN_DEF,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - SOF/LEN/payload/CHK frame parser with buffered output
//
// Purpose: parses frames SOF, LEN, LEN payload bytes, CHK (XOR of LEN and
// payload), buffers the payload and releases it only after the checksum
// verifies, using a valid/ready handshake.
// Ports:
//   clk_50M        - clock, all logic on posedge
//   rst_n          - asynchronous active-low reset
//   i_data_byte    - received byte
//   i_data_avail   - one-cycle strobe, i_data_byte valid
//   i_data_ready   - downstream accepts o_data_byte
//   o_data_byte    - verified payload byte (zero when not valid)
//   o_data_valid   - o_data_byte valid
//   o_frame_len    - LEN of last verified frame
//   o_frame_done   - pulse after last payload byte transfers
//   o_err_len      - pulse, LEN of 0 or above MAX_LEN
//   o_err_chk      - pulse, checksum mismatch
//   o_err_timeout  - pulse, inter-byte timeout
//   o_err_overrun  - pulse, byte dropped while outputting
//   o_busy         - high whenever not idle
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEF,
    parameter int         MAX_LEN      = MAX_LEN_DEF,
    parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] i_data_byte,
    input  logic       i_data_avail,
    input  logic       i_data_ready,
    output logic [7:0] o_data_byte,
    output logic       o_data_valid,
    output logic [4:0] o_frame_len,
    output logic       o_frame_done,
    output logic       o_err_len,
    output logic       o_err_chk,
    output logic       o_err_timeout,
    output logic       o_err_overrun,
    output logic       o_busy
);

    localparam int          BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_t      state;
    logic [4:0]  len;
    logic [4:0]  idx;
    logic [7:0]  chk;
    logic [15:0] to_cnt;
    logic [7:0]  rd_data;

    logic in_frame;
    logic timeout_hit;
    logic wr_en;
    logic len_ok;
    logic last_idx;
    logic handshake;

    // The timeout only runs while a frame is being received; a strobe in the
    // same cycle as the terminal count wins.
    assign in_frame    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign timeout_hit = in_frame && !i_data_avail && (to_cnt == TO_LAST);
    assign wr_en       = (state == ST_PAYLOAD) && i_data_avail;
    assign len_ok      = (i_data_byte != 8'd0) && (i_data_byte <= MAX_LEN_B);
    assign last_idx    = (idx == len - 5'd1);
    assign handshake   = o_data_valid && i_data_ready;
    assign o_busy      = (state != ST_IDLE);
    assign o_data_byte = o_data_valid ? rd_data : 8'h00;

    // Write and read share idx: written during PAYLOAD, read during OUTPUT.
    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (BUF_AW)
    ) u_buf (
        .clk     (clk_50M),
        .wr_en   (wr_en),
        .wr_addr (idx[BUF_AW-1:0]),
        .wr_data (i_data_byte),
        .rd_addr (idx[BUF_AW-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            len           <= 5'd0;
            idx           <= 5'd0;
            chk           <= 8'd0;
            to_cnt        <= 16'd0;
            o_data_valid  <= 1'b0;
            o_frame_len   <= 5'd0;
            o_frame_done  <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;
        end else begin
            o_frame_done  <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;

            if (!in_frame || i_data_avail || timeout_hit) begin
                to_cnt <= 16'd0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end

            if (timeout_hit) begin
                o_err_timeout <= 1'b1;
                state         <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_data_avail && (i_data_byte == SOF_BYTE)) begin
                            state <= ST_LEN;
                        end
                    end

                    ST_LEN: begin
                        if (i_data_avail) begin
                            if (len_ok) begin
                                len   <= i_data_byte[4:0];
                                chk   <= i_data_byte;
                                idx   <= 5'd0;
                                state <= ST_PAYLOAD;
                            end else begin
                                o_err_len <= 1'b1;
                                state     <= ST_IDLE;
                            end
                        end
                    end

                    // SOF values here are ordinary data; no resync.
                    ST_PAYLOAD: begin
                        if (i_data_avail) begin
                            chk <= chk ^ i_data_byte;
                            if (last_idx) begin
                                idx   <= 5'd0;
                                state <= ST_CHECK;
                            end else begin
                                idx <= idx + 5'd1;
                            end
                        end
                    end

                    ST_CHECK: begin
                        if (i_data_avail) begin
                            if (i_data_byte == chk) begin
                                o_frame_len  <= len;
                                o_data_valid <= 1'b1;
                                idx          <= 5'd0;
                                state        <= ST_OUTPUT;
                            end else begin
                                o_err_chk <= 1'b1;
                                state     <= ST_IDLE;
                            end
                        end
                    end

                    ST_OUTPUT: begin
                        if (i_data_avail) begin
                            o_err_overrun <= 1'b1;
                        end
                        if (handshake) begin
                            if (last_idx) begin
                                o_data_valid <= 1'b0;
                                o_frame_done <= 1'b1;
                                idx          <= 5'd0;
                                state        <= ST_IDLE;
                            end else begin
                                idx <= idx + 5'd1;
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - directed self-checking bench for uart_frame_decoder
module tb_uart_frame_decoder;

    localparam int TO = 43400;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic [7:0] i_data_byte;
    logic       i_data_avail;
    logic       i_data_ready;
    logic [7:0] o_data_byte;
    logic       o_data_valid;
    logic [4:0] o_frame_len;
    logic       o_frame_done;
    logic       o_err_len;
    logic       o_err_chk;
    logic       o_err_timeout;
    logic       o_err_overrun;
    logic       o_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor counters, only ever incremented here; tests take deltas.
    logic [7:0] out_q [$];
    int n_done     = 0;
    int n_err_len  = 0;
    int n_err_chk  = 0;
    int n_err_to   = 0;
    int n_err_ovr  = 0;
    int n_err_all  = 0;
    int n_valid    = 0;
    int n_unstable = 0;
    int n_multi    = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    uart_frame_decoder #(
        .SOF_BYTE     (8'hA5),
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .i_data_byte   (i_data_byte),
        .i_data_avail  (i_data_avail),
        .i_data_ready  (i_data_ready),
        .o_data_byte   (o_data_byte),
        .o_data_valid  (o_data_valid),
        .o_frame_len   (o_frame_len),
        .o_frame_done  (o_frame_done),
        .o_err_len     (o_err_len),
        .o_err_chk     (o_err_chk),
        .o_err_timeout (o_err_timeout),
        .o_err_overrun (o_err_overrun),
        .o_busy        (o_busy)
    );

    always #10 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        int errs;
        errs = 32'(o_err_len) + 32'(o_err_chk) + 32'(o_err_timeout) + 32'(o_err_overrun);
        if (o_data_valid && i_data_ready) out_q.push_back(o_data_byte);
        if (o_data_valid) n_valid++;
        if (o_frame_done) n_done++;
        if (o_err_len) n_err_len++;
        if (o_err_chk) n_err_chk++;
        if (o_err_timeout) n_err_to++;
        if (o_err_overrun) n_err_ovr++;
        n_err_all += errs;
        if (errs > 1) n_multi++;
        if (prev_stall && (!o_data_valid || (o_data_byte !== prev_byte))) n_unstable++;
        prev_stall = o_data_valid && !i_data_ready;
        prev_byte  = o_data_byte;
    end

    // Called at posedge+1; strobes the byte for exactly one clock.
    task automatic send_byte(input logic [7:0] b);
        i_data_byte  = b;
        i_data_avail = 1'b1;
        @(posedge clk_50M);
        #1;
        i_data_avail = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_50M);
            #1;
            if (!o_busy && !o_data_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_50M);
        #1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        i_data_byte  = 8'h00;
        i_data_avail = 1'b0;
        i_data_ready = 1'b1;
        repeat (3) @(posedge clk_50M);
        #1;
        n_cmp++;
        if ({o_data_valid, o_frame_done, o_err_len, o_err_chk, o_err_timeout, o_err_overrun, o_busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                {o_data_valid, o_frame_done, o_err_len, o_err_chk, o_err_timeout, o_err_overrun, o_busy});
        end
        n_cmp++;
        if (o_frame_len !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_frame_len: got %0d expected 0", o_frame_len);
        end
        n_cmp++;
        if (o_data_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_byte: got %h expected 00", o_data_byte);
        end
        rst_n = 1'b1;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic test_basic;
        logic [7:0] exp_b [3];
        logic [7:0] got;
        int st, d_done, d_err;
        bit ok;
        exp_b  = '{8'h11, 8'h22, 8'h33};
        st     = out_q.size();
        d_done = n_done;
        d_err  = n_err_all;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);
        wait_idle(50, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic_idle: still busy after 50 cycles, expected idle"); end
        n_cmp++;
        if (out_q.size() - st != 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d bytes expected 3", out_q.size() - st);
        end
        for (int i = 0; i < 3; i++) begin
            got = (st + i < out_q.size()) ? out_q[st + i] : 8'hxx;
            n_cmp++;
            if (got !== exp_b[i]) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, got, exp_b[i]);
            end
        end
        n_cmp++;
        if (o_frame_len !== 5'd3) begin n_fail++; $display("FAIL basic_frame_len: got %0d expected 3", o_frame_len); end
        n_cmp++;
        if (n_done - d_done != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", n_done - d_done); end
        n_cmp++;
        if (n_err_all - d_err != 0) begin n_fail++; $display("FAIL basic_errors: got %0d expected 0", n_err_all - d_err); end
    endtask

    task automatic test_bad_chk;
        int st_v, d_chk, d_err;
        bit ok;
        st_v  = n_valid;
        d_chk = n_err_chk;
        d_err = n_err_all;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
        wait_idle(20, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL badchk_idle: still busy, expected idle"); end
        n_cmp++;
        if (n_err_chk - d_chk != 1) begin n_fail++; $display("FAIL badchk_err_chk: got %0d expected 1", n_err_chk - d_chk); end
        n_cmp++;
        if (n_err_all - d_err != 1) begin n_fail++; $display("FAIL badchk_err_all: got %0d expected 1", n_err_all - d_err); end
        n_cmp++;
        if (n_valid - st_v != 0) begin n_fail++; $display("FAIL badchk_valid: got %0d valid cycles expected 0", n_valid - st_v); end
        n_cmp++;
        if (o_frame_len !== 5'd3) begin n_fail++; $display("FAIL badchk_frame_len: got %0d expected 3", o_frame_len); end
    endtask

    task automatic test_len_err;
        logic [7:0] got;
        int st, d_len, d_err, d_done;
        bit ok;
        d_len  = n_err_len;
        d_err  = n_err_all;
        d_done = n_done;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h11);
        @(posedge clk_50M);
        #1;
        n_cmp++;
        if (n_err_len - d_len != 2) begin n_fail++; $display("FAIL len_err_count: got %0d expected 2", n_err_len - d_len); end
        n_cmp++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL len_err_busy: got %b expected 0", o_busy); end
        st = out_q.size();
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'hA4);
        wait_idle(20, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL sof_data_idle: still busy, expected idle"); end
        n_cmp++;
        if (out_q.size() - st != 1) begin n_fail++; $display("FAIL sof_data_count: got %0d expected 1", out_q.size() - st); end
        got = (st < out_q.size()) ? out_q[st] : 8'hxx;
        n_cmp++;
        if (got !== 8'hA5) begin n_fail++; $display("FAIL sof_data_byte: got %h expected a5", got); end
        n_cmp++;
        if (o_frame_len !== 5'd1) begin n_fail++; $display("FAIL sof_data_frame_len: got %0d expected 1", o_frame_len); end
        n_cmp++;
        if (n_done - d_done != 1) begin n_fail++; $display("FAIL sof_data_done: got %0d expected 1", n_done - d_done); end
        n_cmp++;
        if (n_err_all - d_err != 2) begin n_fail++; $display("FAIL len_err_all: got %0d expected 2", n_err_all - d_err); end
    endtask

    // LEN = MAX_LEN boundary; payload 00..0F XORs to 00, so CHK = 10.
    task automatic test_max_len;
        logic [7:0] got;
        int st, d_err, n_bad;
        bit ok;
        st    = out_q.size();
        d_err = n_err_all;
        send_byte(8'hA5);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h10);
        wait_idle(60, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL maxlen_idle: still busy, expected idle"); end
        n_cmp++;
        if (out_q.size() - st != 16) begin n_fail++; $display("FAIL maxlen_count: got %0d expected 16", out_q.size() - st); end
        n_bad = 0;
        for (int i = 0; i < 16; i++) begin
            got = (st + i < out_q.size()) ? out_q[st + i] : 8'hxx;
            if (got !== 8'(i)) begin
                n_bad++;
                if (n_bad == 1) $display("FAIL maxlen_byte%0d: got %h expected %h", i, got, 8'(i));
            end
        end
        n_cmp++;
        if (n_bad != 0) n_fail++;
        n_cmp++;
        if (o_frame_len !== 5'd16) begin n_fail++; $display("FAIL maxlen_frame_len: got %0d expected 16", o_frame_len); end
        n_cmp++;
        if (n_err_all - d_err != 0) begin n_fail++; $display("FAIL maxlen_errors: got %0d expected 0", n_err_all - d_err); end
    endtask

    task automatic test_timeout;
        int at, d_to, d_err, st;
        logic busy_at;
        at      = -1;
        busy_at = 1'bx;
        d_to    = n_err_to;
        d_err   = n_err_all;
        st      = out_q.size();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        for (int k = 1; k <= TO + 10; k++) begin
            @(posedge clk_50M);
            #1;
            if (o_err_timeout) begin
                at      = k;
                busy_at = o_busy;
                break;
            end
        end
        @(posedge clk_50M);
        #1;
        n_cmp++;
        if (at != TO) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", at, TO); end
        n_cmp++;
        if (busy_at !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy_at); end
        n_cmp++;
        if (n_err_to - d_to != 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", n_err_to - d_to); end
        n_cmp++;
        if (n_err_all - d_err != 1) begin n_fail++; $display("FAIL timeout_err_all: got %0d expected 1", n_err_all - d_err); end
        n_cmp++;
        if (out_q.size() - st != 0) begin n_fail++; $display("FAIL timeout_output: got %0d bytes expected 0", out_q.size() - st); end
    endtask

    // CHK = 04 ^ DE ^ AD ^ BE ^ EF = 26.
    task automatic test_backpressure;
        logic [7:0] exp_b [4];
        logic [7:0] got;
        int st, d_ovr, d_uns, d_done, d_err;
        bit ok;
        exp_b  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        st     = out_q.size();
        d_ovr  = n_err_ovr;
        d_uns  = n_unstable;
        d_done = n_done;
        d_err  = n_err_all;
        i_data_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h26);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            i_data_ready = c[0];
            i_data_byte  = 8'h55;
            i_data_avail = (c == 1);
            @(posedge clk_50M);
            #1;
            i_data_avail = 1'b0;
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        i_data_ready = 1'b1;
        @(posedge clk_50M);
        #1;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL bp_idle: still busy after 40 cycles, expected idle"); end
        n_cmp++;
        if (out_q.size() - st != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", out_q.size() - st); end
        for (int i = 0; i < 4; i++) begin
            got = (st + i < out_q.size()) ? out_q[st + i] : 8'hxx;
            n_cmp++;
            if (got !== exp_b[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        n_cmp++;
        if (n_unstable - d_uns != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", n_unstable - d_uns); end
        n_cmp++;
        if (n_err_ovr - d_ovr != 1) begin n_fail++; $display("FAIL bp_overrun: got %0d expected 1", n_err_ovr - d_ovr); end
        n_cmp++;
        if (n_err_all - d_err != 1) begin n_fail++; $display("FAIL bp_err_all: got %0d expected 1", n_err_all - d_err); end
        n_cmp++;
        if (n_done - d_done != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", n_done - d_done); end
        n_cmp++;
        if (o_frame_len !== 5'd4) begin n_fail++; $display("FAIL bp_frame_len: got %0d expected 4", o_frame_len); end
    endtask

    // New frame CHK = 02 ^ 77 ^ 88 = FD.
    task automatic test_reset_mid;
        logic [7:0] got;
        int st, d_err;
        bit ok;
        st    = out_q.size();
        d_err = n_err_all;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_busy: got %b expected 0", o_busy); end
        n_cmp++;
        if (o_frame_len !== 5'd0) begin n_fail++; $display("FAIL rstmid_frame_len: got %0d expected 0", o_frame_len); end
        @(posedge clk_50M);
        #1;
        rst_n = 1'b1;
        @(posedge clk_50M);
        #1;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'hFD);
        wait_idle(30, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_idle: still busy, expected idle"); end
        n_cmp++;
        if (out_q.size() - st != 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", out_q.size() - st); end
        got = (st < out_q.size()) ? out_q[st] : 8'hxx;
        n_cmp++;
        if (got !== 8'h77) begin n_fail++; $display("FAIL rstmid_byte0: got %h expected 77", got); end
        got = (st + 1 < out_q.size()) ? out_q[st + 1] : 8'hxx;
        n_cmp++;
        if (got !== 8'h88) begin n_fail++; $display("FAIL rstmid_byte1: got %h expected 88", got); end
        n_cmp++;
        if (o_frame_len !== 5'd2) begin n_fail++; $display("FAIL rstmid_frame_len_new: got %0d expected 2", o_frame_len); end
        n_cmp++;
        if (n_err_all - d_err != 0) begin n_fail++; $display("FAIL rstmid_errors: got %0d expected 0", n_err_all - d_err); end
        n_cmp++;
        if (n_multi != 0) begin n_fail++; $display("FAIL multi_error_cycles: got %0d expected 0", n_multi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_len_err();
        test_max_len();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
